// File: rtl/mcb_tester_pkg.sv
// Shared constants for the MCB port tester: command encodings, FSM states,
// pattern modes and the LFSR definition used by the pattern generator.
package mcb_tester_pkg;

    // MCB command instructions (auto-precharge variants)
    localparam logic [2:0] INSTR_WR = 3'b010;
    localparam logic [2:0] INSTR_RD = 3'b011;

    // Tester FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_FILL  = 3'd1;
    localparam logic [2:0] ST_WR_CMD   = 3'd2;
    localparam logic [2:0] ST_WR_DRAIN = 3'd3;
    localparam logic [2:0] ST_RD_CMD   = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    // Pattern modes
    localparam logic [1:0] MODE_LFSR     = 2'd0;
    localparam logic [1:0] MODE_ADDR     = 2'd1;
    localparam logic [1:0] MODE_WALK     = 2'd2;
    localparam logic [1:0] MODE_INV_LFSR = 2'd3;

    // Galois LFSR for x^32+x^22+x^2+x+1, right-shifting form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) begin
            n = n ^ LFSR_POLY;
        end
        return n;
    endfunction

endpackage

// File: rtl/mcb_pattern_gen.sv
// Pattern generator shared by the write and read phases.
// Ports: clk/rst; restart reloads seed state; advance steps one word;
// mode selects the pattern; byte_addr feeds address-as-data;
// pattern_c is the current word (combinational in byte_addr and mode).
module mcb_pattern_gen
    import mcb_tester_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  advance,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] byte_addr,
    output logic [DATA_WIDTH-1:0] pattern_c
);

    localparam int unsigned REP = DATA_WIDTH / 32;

    logic [31:0]           lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] walk_q, walk_d;

    // Next-state: restart has priority over advance
    always_comb begin
        lfsr_d = lfsr_q;
        walk_d = walk_q;
        if (restart) begin
            lfsr_d = LFSR_SEED;
            walk_d = DATA_WIDTH'(1);
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
            walk_d = {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            walk_q <= DATA_WIDTH'(1);
        end else begin
            lfsr_q <= lfsr_d;
            walk_q <= walk_d;
        end
    end

    // Output word selection
    always_comb begin
        pattern_c = '0;
        case (mode)
            MODE_LFSR:     pattern_c = {REP{lfsr_q}};
            MODE_ADDR:     pattern_c = DATA_WIDTH'(byte_addr);
            MODE_WALK:     pattern_c = walk_q;
            MODE_INV_LFSR: pattern_c = ~{REP{lfsr_q}};
            default:       pattern_c = '0;
        endcase
    end

endmodule

// File: rtl/mcb_port_tester.sv
// Self-checking traffic generator for one MCB user port. Writes NUM_BURSTS
// bursts of pattern data, reads them back and compares against the
// regenerated pattern.
// Ports: clk/rst; calib_done/start/mode/loop_en control; cmd_*, wr_*, rd_*
// MCB FIFO interfaces; busy/done/pass/fault/error_count/first_err_addr/
// pass_count status; led = {fault, pass, done, busy, error_count[3:0]}.
// cmd_*, wr_en, wr_data and rd_en are decoded from state and FIFO flags so
// the FIFO handshakes complete in the same cycle.
module mcb_port_tester
    import mcb_tester_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned NUM_BURSTS = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ERR_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    calib_done,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    loop_en,
    output logic                    cmd_en,
    output logic [2:0]              cmd_instr,
    output logic [5:0]              cmd_bl,
    output logic [ADDR_WIDTH-1:0]   cmd_byte_addr,
    input  logic                    cmd_full,
    output logic                    wr_en,
    output logic [DATA_WIDTH/8-1:0] wr_mask,
    output logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_full,
    input  logic                    wr_empty,
    input  logic                    wr_underrun,
    output logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_empty,
    input  logic                    rd_overflow,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fault,
    output logic [ERR_WIDTH-1:0]    error_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    output logic [ERR_WIDTH-1:0]    pass_count,
    output logic [7:0]              led
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned WCNT_W = $clog2(BURST_LEN) + 1;
    localparam int unsigned BCNT_W = $clog2(NUM_BURSTS) + 1;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BURST_LEN * BYTES);
    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [WCNT_W-1:0]     LAST_WORD  = WCNT_W'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0]     LAST_BURST = BCNT_W'(NUM_BURSTS - 1);
    localparam logic [WDOG_W-1:0]     WDOG_LIMIT = WDOG_W'(TIMEOUT);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX    = '1;

    logic [2:0]            state, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [WCNT_W-1:0]     word_cnt, word_cnt_d;
    logic [BCNT_W-1:0]     burst_cnt, burst_cnt_d;
    logic [ADDR_WIDTH-1:0] burst_addr, burst_addr_d, cur_addr;
    logic [WDOG_W-1:0]     wdog, wdog_d;
    logic                  busy_d, done_d, pass_d, fault_d;
    logic [ERR_WIDTH-1:0]  error_count_d, pass_count_d;
    logic [ADDR_WIDTH-1:0] first_err_addr_d;
    logic                  gen_restart, gen_advance;
    logic                  launch, relaunch, finish, abort, progress, in_run;
    logic [DATA_WIDTH-1:0] pattern_c;

    assign cur_addr = burst_addr + ADDR_WIDTH'(word_cnt) * ADDR_WIDTH'(BYTES);
    assign in_run   = (state != ST_IDLE) && (state != ST_DONE);

    mcb_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_gen (
        .clk       (clk),
        .rst       (rst),
        .restart   (gen_restart),
        .advance   (gen_advance),
        .mode      (mode_q),
        .byte_addr (cur_addr),
        .pattern_c (pattern_c)
    );

    // MCB interface decode
    assign cmd_en        = (state == ST_WR_CMD) || (state == ST_RD_CMD);
    assign cmd_instr     = (state == ST_WR_CMD) ? INSTR_WR :
                           (state == ST_RD_CMD) ? INSTR_RD : 3'b000;
    assign cmd_bl        = cmd_en ? 6'(BURST_LEN - 1) : 6'd0;
    assign cmd_byte_addr = cmd_en ? burst_addr : '0;
    assign wr_en         = (state == ST_WR_FILL) && !wr_full;
    assign wr_data       = (state == ST_WR_FILL) ? pattern_c : '0;
    assign wr_mask       = '0;
    assign rd_en         = (state == ST_RD_DATA) && !rd_empty;
    assign led           = {fault, pass, done, busy, error_count[3:0]};

    // Next-state and status update
    always_comb begin
        state_d          = state;
        mode_d           = mode_q;
        word_cnt_d       = word_cnt;
        burst_cnt_d      = burst_cnt;
        burst_addr_d     = burst_addr;
        wdog_d           = wdog;
        busy_d           = busy;
        done_d           = done;
        pass_d           = pass;
        fault_d          = fault;
        error_count_d    = error_count;
        first_err_addr_d = first_err_addr;
        pass_count_d     = pass_count;
        gen_restart      = 1'b0;
        gen_advance      = 1'b0;
        launch           = 1'b0;
        relaunch         = 1'b0;
        finish           = 1'b0;
        abort            = 1'b0;
        progress         = 1'b0;

        case (state)
            ST_IDLE: launch = start && calib_done;

            ST_WR_FILL: begin
                if (!wr_full) begin
                    progress    = 1'b1;
                    gen_advance = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = ST_WR_CMD;
                    end else begin
                        word_cnt_d = word_cnt + WCNT_W'(1);
                    end
                end
            end

            ST_WR_CMD: begin
                if (!cmd_full) begin
                    progress     = 1'b1;
                    burst_addr_d = burst_addr + STRIDE;
                    if (burst_cnt == LAST_BURST) begin
                        burst_cnt_d = '0;
                        state_d     = ST_WR_DRAIN;
                    end else begin
                        burst_cnt_d = burst_cnt + BCNT_W'(1);
                        state_d     = ST_WR_FILL;
                    end
                end
            end

            // Leaving drain restarts the watchdog for the read phase
            ST_WR_DRAIN: begin
                if (wr_empty) begin
                    progress     = 1'b1;
                    gen_restart  = 1'b1;
                    burst_addr_d = BASE;
                    state_d      = ST_RD_CMD;
                end
            end

            ST_RD_CMD: begin
                if (!cmd_full) begin
                    progress = 1'b1;
                    state_d  = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (!rd_empty) begin
                    progress    = 1'b1;
                    gen_advance = 1'b1;
                    if (rd_data != pattern_c) begin
                        if (error_count != ERR_MAX) begin
                            error_count_d = error_count + ERR_WIDTH'(1);
                        end
                        // error_count never returns to zero within a run
                        if (error_count == '0) begin
                            first_err_addr_d = cur_addr;
                        end
                    end
                    if (word_cnt == LAST_WORD) begin
                        word_cnt_d   = '0;
                        burst_addr_d = burst_addr + STRIDE;
                        if (burst_cnt == LAST_BURST) begin
                            burst_cnt_d = '0;
                            finish      = 1'b1;
                        end else begin
                            burst_cnt_d = burst_cnt + BCNT_W'(1);
                            state_d     = ST_RD_CMD;
                        end
                    end else begin
                        word_cnt_d = word_cnt + WCNT_W'(1);
                    end
                end
            end

            // Soak looping stops once a fault has been recorded
            ST_DONE: begin
                if (loop_en && !fault && calib_done) begin
                    relaunch = 1'b1;
                end else begin
                    launch = start && calib_done;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // FIFO faults, watchdog and calibration loss while running
        if (in_run) begin
            if (wr_underrun || rd_overflow) begin
                fault_d = 1'b1;
            end
            if (progress) begin
                wdog_d = '0;
            end else begin
                wdog_d = wdog + WDOG_W'(1);
                if (wdog_d == WDOG_LIMIT) begin
                    abort = 1'b1;
                end
            end
            if (!calib_done) begin
                abort = 1'b1;
            end
        end

        // End of pass; abort overrides a simultaneous normal finish
        if (finish || abort) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            wdog_d      = '0;
            word_cnt_d  = '0;
            burst_cnt_d = '0;
            if (abort) begin
                fault_d = 1'b1;
            end
            pass_d = !abort && !fault_d && (error_count_d == '0);
            if (!abort && (pass_count != ERR_MAX)) begin
                pass_count_d = pass_count + ERR_WIDTH'(1);
            end
        end

        // Fresh run clears results; a looped pass keeps accumulating
        if (launch) begin
            mode_d           = mode;
            error_count_d    = '0;
            first_err_addr_d = '0;
            pass_count_d     = '0;
            fault_d          = 1'b0;
        end
        if (launch || relaunch) begin
            state_d      = ST_WR_FILL;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            gen_restart  = 1'b1;
            burst_addr_d = BASE;
            word_cnt_d   = '0;
            burst_cnt_d  = '0;
            wdog_d       = '0;
        end
    end

    // State and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            mode_q         <= MODE_LFSR;
            word_cnt       <= '0;
            burst_cnt      <= '0;
            burst_addr     <= '0;
            wdog           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fault          <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            pass_count     <= '0;
        end else begin
            state          <= state_d;
            mode_q         <= mode_d;
            word_cnt       <= word_cnt_d;
            burst_cnt      <= burst_cnt_d;
            burst_addr     <= burst_addr_d;
            wdog           <= wdog_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            fault          <= fault_d;
            error_count    <= error_count_d;
            first_err_addr <= first_err_addr_d;
            pass_count     <= pass_count_d;
        end
    end

endmodule

// File: tb/tb_mcb_port_tester.sv
// Directed bench for mcb_port_tester with a behavioural MCB port model.
module tb_mcb_port_tester;

    localparam int DW   = 32;
    localparam int AW   = 30;
    localparam int BL   = 64;
    localparam int NB   = 4;
    localparam int TOT  = BL * NB;
    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic          clk = 1'b0;
    logic          rst;
    logic          calib_done, start, loop_en;
    logic [1:0]    mode;
    logic          cmd_en, cmd_full;
    logic [2:0]    cmd_instr;
    logic [5:0]    cmd_bl;
    logic [AW-1:0] cmd_byte_addr;
    logic          wr_en, wr_full, wr_empty, wr_underrun;
    logic [3:0]    wr_mask;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_en, rd_empty, rd_overflow;
    logic          busy, done, pass, fault;
    logic [15:0]   error_count, pass_count;
    logic [AW-1:0] first_err_addr;
    logic [7:0]    led;

    mcb_port_tester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .NUM_BURSTS(NB),
        .BASE_ADDR(0), .ERR_WIDTH(16), .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst(rst), .calib_done(calib_done), .start(start),
        .mode(mode), .loop_en(loop_en), .cmd_en(cmd_en), .cmd_instr(cmd_instr),
        .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
        .wr_empty(wr_empty), .wr_underrun(wr_underrun), .rd_en(rd_en),
        .rd_data(rd_data), .rd_empty(rd_empty), .rd_overflow(rd_overflow),
        .busy(busy), .done(done), .pass(pass), .fault(fault),
        .error_count(error_count), .first_err_addr(first_err_addr),
        .pass_count(pass_count), .led(led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] exp_word(input logic [1:0] m, input int idx, input logic [31:0] l);
        logic [31:0] one;
        one = 32'd1;
        case (m)
            2'd0:    return l;
            2'd1:    return 32'(idx * 4);
            2'd2:    return one << (idx % 32);
            default: return ~l;
        endcase
    endfunction

    // ---------------- MCB port model ----------------
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] mem[int];
    int          wr_idx, wcmd_cnt, rcmd_cnt, wbad, cbad, first_rd_cyc;
    logic [31:0] exp_lfsr;
    bit          m_rand = 1'b0, m_corrupt = 1'b0, m_nord = 1'b0;
    logic [1:0]  m_mode = 2'd0;

    initial begin
        bit          s_start, s_wa, s_ca, s_ra;
        logic [31:0] s_wd, s_addr;
        logic [2:0]  s_instr;
        logic [5:0]  s_bl;
        logic [31:0] d;
        int          key;
        wr_full = 1'b0; cmd_full = 1'b0; wr_empty = 1'b1; rd_empty = 1'b1; rd_data = '0;
        wr_idx = 0; wcmd_cnt = 0; rcmd_cnt = 0; wbad = 0; cbad = 0; first_rd_cyc = 0;
        exp_lfsr = SEED;
        forever begin
            @(negedge clk);
            s_start = start && calib_done && !busy;
            s_wa    = wr_en && !wr_full;
            s_wd    = wr_data;
            s_ca    = cmd_en && !cmd_full;
            s_instr = cmd_instr;
            s_bl    = cmd_bl;
            s_addr  = 32'(cmd_byte_addr);
            s_ra    = rd_en;
            @(posedge clk);
            #1;
            if (s_start) begin
                wq.delete(); rq.delete();
                wr_idx = 0; wcmd_cnt = 0; rcmd_cnt = 0; wbad = 0; cbad = 0;
                exp_lfsr = SEED;
            end
            if (s_wa) begin
                if (s_wd !== exp_word(m_mode, wr_idx, exp_lfsr)) wbad++;
                wq.push_back(s_wd);
                exp_lfsr = lfsr_step(exp_lfsr);
                wr_idx++;
                if (wr_idx == TOT) begin
                    wr_idx = 0;
                    exp_lfsr = SEED;
                end
            end
            if (s_ra && rq.size() > 0) void'(rq.pop_front());
            if (s_ca) begin
                key = int'(s_addr >> 2);
                if (s_bl != 6'(BL - 1)) cbad++;
                if (s_instr == 3'b010) begin
                    if (s_addr != 32'((wcmd_cnt % NB) * BL * 4)) cbad++;
                    if (wq.size() < BL) cbad++;
                    for (int i = 0; i < BL; i++)
                        if (wq.size() > 0) mem[key + i] = wq.pop_front();
                    wcmd_cnt++;
                end else if (s_instr == 3'b011) begin
                    if (s_addr != 32'((rcmd_cnt % NB) * BL * 4)) cbad++;
                    if (rcmd_cnt == 0) first_rd_cyc = cyc;
                    for (int i = 0; i < BL; i++) begin
                        d = mem.exists(key + i) ? mem[key + i] : 32'hDEAD_BEEF;
                        if (m_corrupt && (rcmd_cnt % NB) == 2 && i == 5) d = d ^ 32'd1;
                        if (!m_nord) rq.push_back(d);
                    end
                    rcmd_cnt++;
                end else begin
                    cbad++;
                end
            end
            wr_full  = m_rand ? 1'($urandom_range(1, 0)) : 1'b0;
            cmd_full = m_rand ? 1'($urandom_range(1, 0)) : 1'b0;
            wr_empty = (wq.size() == 0);
            rd_empty = (rq.size() == 0);
            rd_data  = (rq.size() > 0) ? rq[0] : '0;
        end
    end

    // ---------------- test sequences ----------------
    typedef struct {
        logic [1:0]  mode;
        bit          rnd;
        bit          corrupt;
        bit          nord;
        logic [15:0] err;
        logic [31:0] first;
        bit          pass;
        bit          fault;
        int          wcmds;
        int          rcmds;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[7];

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk); #1;
        mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_status"}, 32'({busy, done, pass, fault, led}), 32'd0);
        chk({name, "_mcb"}, 32'({cmd_en, cmd_instr, cmd_bl, wr_en, rd_en, wr_mask}), 32'd0);
        chk({name, "_addr"}, 32'(cmd_byte_addr) | 32'(first_err_addr), 32'd0);
        chk({name, "_data"}, wr_data, 32'd0);
        chk({name, "_cnt"}, {error_count, pass_count}, 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; calib_done = 1'b1; start = 1'b0; loop_en = 1'b0; mode = 2'd0;
        wr_underrun = 1'b0; rd_overflow = 1'b0;

        vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h000, 1'b1, 1'b0, 4, 4, 16'd1};
        vecs[1] = '{2'd0, 1'b0, 1'b1, 1'b0, 16'd1, 32'h214, 1'b0, 1'b0, 4, 4, 16'd1};
        vecs[2] = '{2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 32'h000, 1'b1, 1'b0, 4, 4, 16'd1};
        vecs[3] = '{2'd2, 1'b0, 1'b0, 1'b0, 16'd0, 32'h000, 1'b1, 1'b0, 4, 4, 16'd1};
        vecs[4] = '{2'd3, 1'b1, 1'b0, 1'b0, 16'd0, 32'h000, 1'b1, 1'b0, 4, 4, 16'd1};
        vecs[5] = '{2'd0, 1'b0, 1'b0, 1'b1, 16'd0, 32'h000, 1'b0, 1'b1, 4, 1, 16'd0};
        vecs[6] = '{2'd2, 1'b0, 1'b1, 1'b0, 16'd1, 32'h214, 1'b0, 1'b0, 4, 4, 16'd1};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // start without calibration is ignored
        calib_done = 1'b0;
        pulse_start(2'd0);
        repeat (5) @(negedge clk);
        chk("nocal_busy", 32'({busy, cmd_en, wr_en}), 32'd0);
        @(posedge clk); #1;
        calib_done = 1'b1;

        foreach (vecs[i]) begin
            m_mode = vecs[i].mode; m_rand = vecs[i].rnd;
            m_corrupt = vecs[i].corrupt; m_nord = vecs[i].nord;
            pulse_start(vecs[i].mode);
            wait_done($sformatf("v%0d", i), 4000);
            lat = cyc - first_rd_cyc;
            chk($sformatf("v%0d_err", i), 32'(error_count), 32'(vecs[i].err));
            chk($sformatf("v%0d_first", i), 32'(first_err_addr), vecs[i].first);
            chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].pass));
            chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].fault));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_pc", i), 32'(pass_count), 32'(vecs[i].pc));
            chk($sformatf("v%0d_wcmds", i), wcmd_cnt, vecs[i].wcmds);
            chk($sformatf("v%0d_rcmds", i), rcmd_cnt, vecs[i].rcmds);
            chk($sformatf("v%0d_wdata", i), wbad, 32'd0);
            chk($sformatf("v%0d_cmd", i), cbad, 32'd0);
            chk($sformatf("v%0d_led", i), 32'(led),
                32'({vecs[i].fault, vecs[i].pass, 1'b1, 1'b0, vecs[i].err[3:0]}));
            if (vecs[i].nord)
                chk($sformatf("v%0d_timeout_latency_ok(lat=%0d)", i, lat),
                    32'(lat >= 98 && lat <= 102), 32'd1);
        end
        m_rand = 1'b0; m_corrupt = 1'b0; m_nord = 1'b0;

        // soak loop: three passes, then calibration loss during the fourth
        m_mode = 2'd0;
        @(posedge clk); #1;
        loop_en = 1'b1;
        pulse_start(2'd0);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (pass_count == 16'd3) break;
        end
        chk("loop_pc3", 32'(pass_count), 32'd3);
        repeat (40) @(posedge clk);
        #1;
        chk("loop_busy4", 32'(busy), 32'd1);
        calib_done = 1'b0;
        wait_done("calloss", 20);
        chk("calloss_fault", 32'(fault), 32'd1);
        chk("calloss_pass", 32'(pass), 32'd0);
        chk("calloss_pc", 32'(pass_count), 32'd3);
        chk("calloss_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        calib_done = 1'b1;
        loop_en = 1'b0;

        // write underrun flags a fault; a second start mid-run is ignored
        m_mode = 2'd1;
        pulse_start(2'd1);
        repeat (20) @(posedge clk);
        #1;
        wr_underrun = 1'b1; mode = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        wr_underrun = 1'b0; start = 1'b0;
        wait_done("urun", 4000);
        chk("urun_fault", 32'(fault), 32'd1);
        chk("urun_pass", 32'(pass), 32'd0);
        chk("urun_err", 32'(error_count), 32'd0);
        chk("urun_pc", 32'(pass_count), 32'd1);
        chk("urun_wdata", wbad, 32'd0);
        chk("urun_wcmds", wcmd_cnt, 32'd4);

        // asynchronous reset mid-run
        m_mode = 2'd0;
        pulse_start(2'd0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("arst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_zero("arst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_idle", 32'({busy, done, cmd_en, wr_en}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "bench timeout");
    end

endmodule
